// File: rtl/lamp_sequence_generator_pkg.sv
// Shared types and default widths for the lamp-sequence transmit side.
package lamp_seq_pkg;

  localparam int unsigned NBITS  = 3;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned REP_W  = 3;

  typedef enum logic [NBITS-1:0] {
    IDLE,
    ON1,
    ON2,
    ON3,
    GAP,
    FINISH
  } gen_state_t;

endpackage

// File: rtl/lamp_sequence_generator_down_counter.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/lamp_sequence_generator.sv
// Lamp-sequence generator: runs a configurable number of 1-2-3 lamp passes per start pulse.
module lamp_sequence_generator #(
  parameter int unsigned NBITS  = lamp_seq_pkg::NBITS,
  parameter int unsigned HOLD_W = lamp_seq_pkg::HOLD_W,
  parameter int unsigned REP_W  = lamp_seq_pkg::REP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] dwell,
  input  logic [HOLD_W-1:0] gap,
  input  logic [REP_W-1:0]  passes,
  output logic              Lampada1,
  output logic              Lampada2,
  output logic              Lampada3,
  output logic              busy,
  output logic              done
);

  import lamp_seq_pkg::*;

  // State width is owned by the package enum; a mismatched override is rejected here.
  if (NBITS != $bits(gen_state_t)) begin : g_nbits_mismatch
    $error("NBITS must equal the width of gen_state_t");
  end

  gen_state_t        r_state, w_next;
  logic [HOLD_W-1:0] r_dwell, r_gap;

  logic              w_hold_load, w_hold_dec, w_hold_zero;
  logic [HOLD_W-1:0] w_hold_ld_val, w_hold_val;
  logic              w_rem_load, w_rem_dec, w_rem_zero;
  logic [REP_W-1:0]  w_rem_val;
  logic              w_start_ok, w_last;

  assign w_start_ok = start && !abort && (passes != '0);
  assign w_last     = (w_rem_val == REP_W'(1));

  down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_dec      (w_hold_dec),
    .i_load_val (w_hold_ld_val),
    .o_value    (w_hold_val),
    .o_zero     (w_hold_zero)
  );

  down_counter #(.W(REP_W)) u_pass_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rem_load),
    .i_dec      (w_rem_dec),
    .i_load_val (passes),
    .o_value    (w_rem_val),
    .o_zero     (w_rem_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_start_ok) begin
        r_dwell <= dwell;
        r_gap   <= gap;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_hold_load   = 1'b0;
    w_hold_dec    = 1'b0;
    w_hold_ld_val = r_dwell;
    w_rem_load    = 1'b0;
    w_rem_dec     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_next        = ON1;
          w_hold_load   = 1'b1;
          w_hold_ld_val = dwell;
          w_rem_load    = 1'b1;
        end
      end
      ON1: begin
        if (abort)            w_next = IDLE;
        else if (w_hold_zero) w_next = ON2;
        else                  w_hold_dec = 1'b1;
      end
      ON2: w_next = abort ? IDLE : ON3;
      ON3: begin
        if (abort) begin
          w_next = IDLE;
        end else begin
          w_rem_dec = 1'b1;
          if (w_last) begin
            w_next = FINISH;
          end else if (r_gap == '0) begin
            w_next      = ON1;
            w_hold_load = 1'b1;
          end else begin
            w_next        = GAP;
            w_hold_load   = 1'b1;
            w_hold_ld_val = r_gap - HOLD_W'(1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_hold_zero) begin
          w_next      = ON1;
          w_hold_load = 1'b1;
        end else begin
          w_hold_dec = 1'b1;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign Lampada1 = (r_state == ON1);
  assign Lampada2 = (r_state == ON2);
  assign Lampada3 = (r_state == ON3);
  assign busy     = (r_state == ON1) || (r_state == ON2) || (r_state == ON3) || (r_state == GAP);
  assign done     = (r_state == FINISH);

  a_rem_live: assert property (@(posedge clk) disable iff (reset)
    busy |-> !w_rem_zero);
  a_gap_bound: assert property (@(posedge clk) disable iff (reset)
    (r_state == GAP) |-> (w_hold_val < r_gap));

endmodule
